// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded ID fields and EX/MEM hazard info in,
// registered EX fields and the load-use stall request out.
interface id_ex_stage_reg_if #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
);
  logic               id_valid;
  logic [REG_AW-1:0]  id_rs1, id_rs2, id_rd;
  logic               id_use_rs1, id_use_rs2;
  logic [XLEN-1:0]    id_read_data_1, id_read_data_2, id_imm;
  logic               id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic [ALUOP_W-1:0] id_alu_op;
  logic [REG_AW-1:0]  mem_rd;
  logic               mem_reg_write;
  logic               flush, hold;

  logic               stall_ifid;
  logic               ex_valid;
  logic [REG_AW-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]    ex_read_data_1, ex_read_data_2, ex_imm;
  logic               ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [1:0]         ex_forward_a, ex_forward_b;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_read_data_1, id_read_data_2, id_imm,
           id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_alu_op,
           mem_rd, mem_reg_write, flush, hold,
    output stall_ifid, ex_valid, ex_rs1, ex_rs2, ex_rd,
           ex_read_data_1, ex_read_data_2, ex_imm,
           ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_alu_op,
           ex_forward_a, ex_forward_b
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_read_data_1, id_read_data_2, id_imm,
           id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_alu_op,
           mem_rd, mem_reg_write, flush, hold,
    input  stall_ifid, ex_valid, ex_rs1, ex_rs2, ex_rd,
           ex_read_data_1, ex_read_data_2, ex_imm,
           ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_alu_op,
           ex_forward_a, ex_forward_b
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall detection, branch flush and
// forwarding selects pre-decoded in ID so EX sees only a registered mux select.
module id_ex_stage_reg #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input logic clk,
  input logic rst,
  id_ex_stage_reg_if.slave bus
);

  typedef struct packed {
    logic               valid;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [REG_AW-1:0]  rd;
    logic [XLEN-1:0]    read_data_1;
    logic [XLEN-1:0]    read_data_2;
    logic [XLEN-1:0]    imm;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         forward_a;
    logic [1:0]         forward_b;
  } ex_t;

  ex_t  ex_q;
  ex_t  load_d;
  logic stall;

  // EX/MEM (10) beats WB (01); the instruction now in EX reaches MEM next cycle.
  function automatic logic [1:0] fwd_sel(
    input logic              use_rs,
    input logic [REG_AW-1:0] rs,
    input logic              ex_hit_en,
    input logic [REG_AW-1:0] ex_rd,
    input logic              mem_hit_en,
    input logic [REG_AW-1:0] mem_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs) begin
      if (ex_hit_en && (ex_rd != '0) && (ex_rd == rs))
        sel = 2'b10;
      else if (mem_hit_en && (mem_rd != '0) && (mem_rd == rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign stall = ~rst & ~bus.flush & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0)
               & bus.id_valid
               & ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.rd))
                | (bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd)));

  always_comb begin
    load_d             = '0;
    load_d.valid       = bus.id_valid;
    load_d.rs1         = bus.id_rs1;
    load_d.rs2         = bus.id_rs2;
    load_d.rd          = bus.id_rd;
    load_d.read_data_1 = bus.id_read_data_1;
    load_d.read_data_2 = bus.id_read_data_2;
    load_d.imm         = bus.id_imm;
    load_d.alu_src     = bus.id_alu_src    & bus.id_valid;
    load_d.mem_read    = bus.id_mem_read   & bus.id_valid;
    load_d.mem_write   = bus.id_mem_write  & bus.id_valid;
    load_d.reg_write   = bus.id_reg_write  & bus.id_valid;
    load_d.mem_to_reg  = bus.id_mem_to_reg & bus.id_valid;
    load_d.alu_op      = bus.id_alu_op & {ALUOP_W{bus.id_valid}};
    if (bus.id_valid) begin
      load_d.forward_a = fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_q.valid & ex_q.reg_write,
                                 ex_q.rd, bus.mem_reg_write, bus.mem_rd);
      load_d.forward_b = fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_q.valid & ex_q.reg_write,
                                 ex_q.rd, bus.mem_reg_write, bus.mem_rd);
    end
  end

  // A bubble is the all-zero record, identical to the reset state.
  always_ff @(posedge clk) begin
    if (rst)
      ex_q <= '0;
    else if (bus.flush)
      ex_q <= '0;
    else if (bus.hold)
      ex_q <= ex_q;
    else if (stall)
      ex_q <= '0;
    else
      ex_q <= load_d;
  end

  assign bus.stall_ifid     = stall;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_rs1         = ex_q.rs1;
  assign bus.ex_rs2         = ex_q.rs2;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_read_data_1 = ex_q.read_data_1;
  assign bus.ex_read_data_2 = ex_q.read_data_2;
  assign bus.ex_imm         = ex_q.imm;
  assign bus.ex_alu_src     = ex_q.alu_src;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.ex_alu_op      = ex_q.alu_op;
  assign bus.ex_forward_a   = ex_q.forward_a;
  assign bus.ex_forward_b   = ex_q.forward_b;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: a cycle-by-cycle vector table with hand-derived
// stall/forward expectations, scored through an expected-value queue.
module tb_id_ex_stage_reg;

  localparam int W = 125;

  logic clk;
  logic rst;

  id_ex_stage_reg_if bus ();

  id_ex_stage_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        r, f, h, vld;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        mr, rw;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] imm;
    logic        es;    // expected stall_ifid during this cycle
    int          src;   // row whose ID fields EX must hold after the edge (-1: zero/bubble)
    logic [1:0]  efa, efb;
  } vec_t;

  vec_t             vecs[$];
  logic [W-1:0]     exp_q[$];
  int               checks = 0;
  int               failures = 0;

  function automatic logic [31:0] rd1_of(input logic [31:0] imm);
    return imm ^ 32'hdead_0000;
  endfunction

  function automatic logic [31:0] rd2_of(input logic [31:0] imm);
    return ~imm;
  endfunction

  task automatic add(input logic r, f, h, vld, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic mr, rw, input logic [4:0] mrd, input logic mrw,
                     input logic [31:0] imm, input logic es, input int src,
                     input logic [1:0] efa, efb);
    vec_t v;
    v.r = r; v.f = f; v.h = h; v.vld = vld;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.rw = rw; v.mrd = mrd; v.mrw = mrw; v.imm = imm;
    v.es = es; v.src = src; v.efa = efa; v.efb = efb;
    vecs.push_back(v);
  endtask

  function automatic logic [W-1:0] exp_word(input int src, input logic [1:0] fa, fb);
    vec_t v;
    logic g;
    if (src < 0) return '0;
    v = vecs[src];
    g = v.vld;
    return {g, v.rs1, v.rs2, v.rd, rd1_of(v.imm), rd2_of(v.imm), v.imm,
            v.imm[4] & g, v.mr & g, v.imm[5] & g, v.rw & g, v.imm[6] & g,
            v.imm[3:0] & {4{g}}, fa, fb};
  endfunction

  function automatic logic [W-1:0] act_word();
    return {bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd,
            bus.ex_read_data_1, bus.ex_read_data_2, bus.ex_imm,
            bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write,
            bus.ex_mem_to_reg, bus.ex_alu_op, bus.ex_forward_a, bus.ex_forward_b};
  endfunction

  // driver: apply one table row; reset rows get random ID-side fields
  task automatic drive(input vec_t v);
    rst      = v.r;
    bus.flush = v.f;
    bus.hold  = v.h;
    if (v.r) begin
      bus.id_valid   = 1'($urandom_range(0, 1));
      bus.id_rs1     = 5'($urandom_range(0, 31));
      bus.id_rs2     = 5'($urandom_range(0, 31));
      bus.id_use_rs1 = 1'($urandom_range(0, 1));
      bus.id_use_rs2 = 1'($urandom_range(0, 1));
      bus.id_rd      = 5'($urandom_range(0, 31));
      bus.id_imm     = $urandom;
      bus.id_mem_read   = 1'($urandom_range(0, 1));
      bus.id_reg_write  = 1'($urandom_range(0, 1));
      bus.mem_rd        = 5'($urandom_range(0, 31));
      bus.mem_reg_write = 1'($urandom_range(0, 1));
    end else begin
      bus.id_valid   = v.vld;
      bus.id_rs1     = v.rs1;
      bus.id_rs2     = v.rs2;
      bus.id_use_rs1 = v.u1;
      bus.id_use_rs2 = v.u2;
      bus.id_rd      = v.rd;
      bus.id_imm     = v.imm;
      bus.id_mem_read   = v.mr;
      bus.id_reg_write  = v.rw;
      bus.mem_rd        = v.mrd;
      bus.mem_reg_write = v.mrw;
    end
    bus.id_read_data_1 = rd1_of(bus.id_imm);
    bus.id_read_data_2 = rd2_of(bus.id_imm);
    bus.id_alu_src     = bus.id_imm[4];
    bus.id_mem_write   = bus.id_imm[5];
    bus.id_mem_to_reg  = bus.id_imm[6];
    bus.id_alu_op      = bus.id_imm[3:0];
  endtask

  // watchdog
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [W-1:0] exp_w;
    logic [W-1:0] got_w;
    rst = 1'b1;
    //   r f h v rs1 u1 rs2 u2 rd mr rw mrd mrw imm     es src fa    fb
    add(1,0,0,1, 0,0, 0,0,  9, 0,1,  0,0, 32'h11,  0,-1, 2'b00,2'b00);
    add(1,0,0,1, 0,0, 0,0,  9, 0,1,  0,0, 32'h12,  0,-1, 2'b00,2'b00);
    add(0,0,0,1, 3,1, 4,1,  5, 0,1,  0,0, 32'h22,  0, 2, 2'b00,2'b00);
    add(0,0,0,1, 5,1, 6,1,  8, 0,1,  0,0, 32'h33,  0, 3, 2'b10,2'b00);
    add(0,0,0,1, 1,1, 2,1,  9, 0,1,  5,1, 32'h44,  0, 4, 2'b00,2'b00);
    add(0,0,0,1, 5,1, 0,1, 10, 0,1,  5,1, 32'h55,  0, 5, 2'b01,2'b00);
    add(0,0,0,1,10,1,10,1, 11, 0,1, 10,1, 32'h66,  0, 6, 2'b10,2'b10);
    add(0,0,0,1, 1,1, 0,0,  7, 1,1,  0,0, 32'h77,  0, 7, 2'b00,2'b00);
    add(0,0,0,1, 2,1, 7,1, 12, 0,1,  0,0, 32'h88,  1,-1, 2'b00,2'b00);
    add(0,0,0,1, 2,1, 7,1, 12, 0,1,  7,1, 32'h88,  0, 9, 2'b00,2'b01);
    add(0,0,0,1, 0,0, 0,0,  0, 1,1,  0,0, 32'h99,  0,10, 2'b00,2'b00);
    add(0,0,0,1, 0,1, 0,1, 13, 0,1,  0,0, 32'ha0,  0,11, 2'b00,2'b00);
    add(0,0,0,1, 1,0, 0,0,  7, 1,1,  0,0, 32'hb0,  0,12, 2'b00,2'b00);
    add(0,0,0,1, 3,1, 7,0, 14, 0,1,  0,0, 32'hc0,  0,13, 2'b00,2'b00);
    add(0,0,0,1, 0,0, 0,0,  7, 1,1,  0,0, 32'hd0,  0,14, 2'b00,2'b00);
    add(0,1,0,1, 7,1, 0,0, 15, 0,1,  0,0, 32'he0,  0,-1, 2'b00,2'b00);
    add(0,0,0,1, 0,0, 0,0,  7, 1,1,  0,0, 32'hf0,  0,16, 2'b00,2'b00);
    add(0,1,1,1, 7,1, 0,0,  3, 0,1,  0,0, 32'h101, 0,-1, 2'b00,2'b00);
    add(0,0,0,1, 0,0, 0,0, 20, 0,1,  0,0, 32'h202, 0,18, 2'b00,2'b00);
    add(0,0,1,1,20,1, 0,0, 21, 1,1,  0,0, 32'h303, 0,18, 2'b00,2'b00);
    add(0,0,1,1, 0,0,20,1, 22, 0,1, 20,1, 32'h404, 0,18, 2'b00,2'b00);
    add(0,0,1,0,20,1,20,1, 23, 1,0,  0,0, 32'h505, 0,18, 2'b00,2'b00);
    add(1,0,1,1, 0,0, 0,0,  0, 0,0,  0,0, 32'h5a5, 0,-1, 2'b00,2'b00);
    add(0,0,0,1, 3,1, 0,0,  5, 0,1,  0,0, 32'h606, 0,23, 2'b00,2'b00);
    add(0,0,0,0, 5,0, 0,0,  6, 1,1,  0,0, 32'h707, 0,24, 2'b00,2'b00);
    add(0,0,0,1, 0,0, 0,0,  7, 1,1,  0,0, 32'h808, 0,25, 2'b00,2'b00);
    add(0,0,1,1, 7,1, 0,0,  9, 0,1,  0,0, 32'h909, 1,25, 2'b00,2'b00);
    add(0,0,0,1, 7,1, 0,0,  9, 0,1,  0,0, 32'h909, 1,-1, 2'b00,2'b00);
    add(0,0,0,1, 7,1, 0,0,  9, 0,1,  7,1, 32'h909, 0,28, 2'b01,2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(exp_word(vecs[i].src, vecs[i].efa, vecs[i].efb));
      #1;
      checks++;
      if (bus.stall_ifid !== vecs[i].es) begin
        failures++;
        $display("FAIL stall_row%0d: got=%b exp=%b", i, bus.stall_ifid, vecs[i].es);
      end
      @(posedge clk);
      #1;
      exp_w = exp_q.pop_front();
      got_w = act_word();
      checks++;
      if (got_w !== exp_w) begin
        failures++;
        $display("FAIL ex_row%0d: got=%h exp=%h", i, got_w, exp_w);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register for the 5-stage core. It sits directly upstream of the EX-stage operand muxes and feeds them the register-file operands, immediate, control bits and pre-decoded forwarding selects. It also contains load-use hazard detection, which stalls IF/ID and inserts a bubble, and it applies branch flushes. Forward selects are computed in ID and registered, which removes the comparators from the EX critical path.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register index width
ALUOP_W, 4, ALU operation field width

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_AW  source register indices
id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
id_rd  in  REG_AW  destination index
id_read_data_1, id_read_data_2  in  XLEN  register-file outputs
id_imm  in  XLEN  sign-extended immediate
id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1  decoded control
id_alu_op  in  ALUOP_W  ALU operation
mem_rd  in  REG_AW  EX/MEM destination index
mem_reg_write  in  1  EX/MEM writes the register file (already 0 for bubbles)
flush  in  1  branch/jump resolved taken in EX
hold  in  1  global pipeline freeze
stall_ifid  out  1  load-use stall request to PC and IF/ID
ex_valid  out  1  EX stage holds a real instruction
ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered indices
ex_read_data_1, ex_read_data_2, ex_imm  out  XLEN  registered operands
ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered control
ex_alu_op  out  ALUOP_W  registered ALU operation
ex_forward_a, ex_forward_b  out  2  operand select: 00 register file, 01 WB Write_data, 10 EX/MEM rd_data; 11 never produced

Behaviour:
- All register updates occur on the rising edge of clk. There is no combinational path from ID inputs to ex_* outputs; latency is 1 cycle.
- Reset (rst=1 on an edge): every ex_* output goes to 0, including ex_valid=0 and ex_forward_*=00. Reset has top priority and may land mid-stall or mid-flush; the next state is the reset state regardless.
- Load-use detection (combinational): stall_ifid = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). stall_ifid is forced to 0 when flush=1 or rst=1.
- Update priority at each edge: rst > flush > hold > load-use bubble > normal load.
- flush=1: load a bubble. A bubble sets ex_valid=0, all control bits 0, ex_forward_*=00, and ex_rd=0. Data fields are don't-care; they are cleared to 0.
- hold=1 (flush=0): all outputs keep their value. stall_ifid is still evaluated on the current contents. The rest of the pipeline is frozen too, so the registered forward selects remain correct.
- Load-use bubble (stall_ifid=1): load a bubble. The ID instruction is retained upstream and re-evaluated next cycle, when the load is in MEM.
- Normal load: capture all id_* fields. A field is qualified by id_valid: ex_valid=id_valid, and if id_valid=0 the controls are loaded as 0.
- Forward pre-decode for operand A; operand B is identical with rs2:
  - 10 when ex_valid & ex_reg_write & ex_rd!=0 & ex_rd==id_rs1. That instruction will be in MEM next cycle.
  - Else 01 when mem_reg_write & mem_rd!=0 & mem_rd==id_rs1. That instruction will be in WB next cycle.
  - Else 00.
  - If id_use_rs1=0, the select is 00.
  - EX/MEM (10) has priority over WB (01) when both match.
- Register x0 is never forwarded and never causes a stall.
- Same-cycle write-then-read through the register file is handled by the register file's internal bypass, not by this block.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all ex_* outputs 0, stall_ifid=0. Release rst, then present the add id_rs1=3, id_rd=5 -> next cycle ex_valid=1, ex_rd=5, ex_forward_a=00.
- Back-to-back dependency: "add x5" is in EX and "sub rs1=x5" is in ID -> the next cycle shows ex_forward_a=10. With one unrelated instruction between them, and mem_rd=5 with mem_reg_write=1 -> ex_forward_a=01. When both match, the result is 10.
- Load-use: "lw x7" is in EX (ex_mem_read=1) and ID has rs2=7 with id_use_rs2=1 -> stall_ifid=1 that cycle and the next ex_valid=0. The following cycle captures the instruction with ex_forward_b=01 (given mem_rd=7, mem_reg_write=1), and stall_ifid=0.
- Load-use targeting x0, or id_use_rs2=0 -> stall_ifid=0 and no bubble.
- flush=1 together with a load-use condition -> stall_ifid=0 and the next state is a bubble. flush=1 together with hold=1 -> bubble; flush wins.
- hold=1 for 3 cycles while ID inputs toggle -> all ex_* outputs unchanged. Assert rst during hold -> outputs cleared on the next edge.
